// File: rtl/dot_max_tracker.sv
// Loads two LANES-wide unsigned banks, evaluates their dot product one lane per
// cycle, and tracks the largest result seen together with the sample index that produced it.
module dot_max_tracker #(
  parameter int LANES = 4,
  parameter int DW    = 4,
  parameter int CNT_W = 8,
  localparam int ACC_W = 2*DW + $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [DW-1:0]    in_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] dot,
  output logic [ACC_W-1:0] max_val,
  output logic [CNT_W-1:0] max_idx,
  output logic             new_max,
  output logic [1:0]       fsm_state
);

  localparam int KW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DW-1:0]    x_bank [LANES];
  logic [DW-1:0]    w_bank [LANES];
  logic [ACC_W-1:0] acc;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] sample_cnt;
  logic             have_max;
  logic             new_max_q;
  logic [2*DW-1:0]  prod;
  logic             load_fire;
  logic             eval_go;
  logic             mac_last;

  // Handshake: a load beat transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready is high exactly when the FSM is idle.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign new_max   = new_max_q;
  assign fsm_state = state;

  assign load_fire = in_valid & in_ready;
  assign eval_go   = (state == IDLE) & start & ~in_valid;
  // The cycle with k == LANES adds nothing; it hands the finished sum to DONE.
  assign mac_last  = (state == MAC) & (k == KW'(LANES));

  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      if (k == KW'(i)) prod = x_bank[i] * w_bank[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (eval_go) state_n = MAC;
      MAC:     if (mac_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        x_bank[i] <= '0;
        w_bank[i] <= '0;
      end
      acc        <= '0;
      k          <= '0;
      dot        <= '0;
      max_val    <= '0;
      max_idx    <= '0;
      sample_cnt <= '0;
      have_max   <= 1'b0;
      new_max_q  <= 1'b0;
    end else begin
      if (load_fire) begin
        for (int i = 0; i < LANES - 1; i++) begin
          if (in_sel) w_bank[i] <= w_bank[i+1];
          else        x_bank[i] <= x_bank[i+1];
        end
        if (in_sel) w_bank[LANES-1] <= in_data;
        else        x_bank[LANES-1] <= in_data;
      end

      if (eval_go) begin
        acc <= '0;
        k   <= '0;
      end else if (state == MAC && !mac_last) begin
        acc <= acc + ACC_W'(prod);
        k   <= k + KW'(1);
      end

      new_max_q <= 1'b0;
      if (mac_last) begin
        dot <= acc;
        // A clear landing on the completion edge discards this sample's max update.
        if (clr) begin
          max_val    <= '0;
          max_idx    <= '0;
          sample_cnt <= '0;
          have_max   <= 1'b0;
        end else begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          if (!have_max || acc > max_val) begin
            max_val   <= acc;
            max_idx   <= sample_cnt;
            have_max  <= 1'b1;
            new_max_q <= 1'b1;
          end
        end
      end else if (clr) begin
        max_val    <= '0;
        max_idx    <= '0;
        sample_cnt <= '0;
        have_max   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dot_max_tracker.md
DOT_MAX_TRACKER -- requirements
Module: dot_max_tracker

Interface
REQ-001 Parameter LANES, default 4, number of input/weight lanes (>=2).
REQ-002 Parameter DW, default 4, unsigned lane width in bits.
REQ-003 Parameter CNT_W, default 8, sample-index counter width.
REQ-004 Derived localparam ACC_W = 2*DW + clog2(LANES), accumulator/result width (10 at defaults).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 clr  in  1  synchronous clear of max tracking state.
REQ-008 in_valid  in  1  load beat valid.
REQ-009 in_ready  out  1  load beat accepted when high with in_valid.
REQ-010 in_sel  in  1  load target: 1=weight bank, 0=input bank.
REQ-011 in_data  in  DW  lane value being loaded.
REQ-012 start  in  1  request one dot-product evaluation.
REQ-013 busy  out  1  evaluation in progress.
REQ-014 done  out  1  one-cycle pulse, result outputs updated.
REQ-015 dot  out  ACC_W  most recent dot product.
REQ-016 max_val  out  ACC_W  greatest dot product since reset/clr.
REQ-017 max_idx  out  CNT_W  sample index that produced max_val.
REQ-018 new_max  out  1  one-cycle pulse with done when max_val changed.

Function
REQ-019 States IDLE, MAC, DONE; busy SHALL equal (state != IDLE); in_ready SHALL equal (state == IDLE).
REQ-020 Load beat (in_valid & in_ready) SHALL shift selected bank: lane[LANES-1] <= in_data, lane[i] <= lane[i+1]; first of LANES beats lands in lane 0; other bank unchanged.
REQ-021 IDLE & start & !in_valid SHALL clear accumulator, lane counter k=0, go to MAC.
REQ-022 start and in_valid in the same IDLE cycle: load SHALL be performed, start ignored.
REQ-023 start, in_valid while busy SHALL be ignored; banks SHALL NOT change during MAC/DONE.
REQ-024 MAC: each cycle acc += x[k]*w[k] (unsigned, full ACC_W, no overflow possible), k++; after lane LANES-1 go to DONE.
REQ-025 DONE entry edge SHALL register dot <= final acc and assert done for exactly the DONE cycle, then return to IDLE.
REQ-026 Latency: start sampled at edge 0 -> done high in cycle after edge LANES+1; next start accepted from the following IDLE cycle.
REQ-027 Max update at same edge as dot: if have_max==0 or acc > max_val (strict unsigned), max_val <= acc, max_idx <= sample_cnt, have_max <= 1, new_max pulses with done.
REQ-028 Ties SHALL NOT update max (earliest index kept).
REQ-029 sample_cnt SHALL increment on every completed evaluation, wrapping 2^CNT_W-1 -> 0.
REQ-030 clr SHALL zero max_val, max_idx, sample_cnt, have_max; in any state; banks, dot, FSM unaffected.
REQ-031 clr coinciding with a DONE-entry edge: dot SHALL update and done pulse, but clr wins for max state and new_max SHALL stay 0.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, zero both banks, acc, k, dot, max_val, max_idx, sample_cnt, have_max; done=0, new_max=0, busy=0, in_ready=1 after release.
REQ-033 Reset during MAC SHALL abort evaluation with no done pulse and no output update.

Verification (LANES=4, DW=4)
REQ-034 Load inputs 1,2,3,4, weights 1,1,1,1, start -> done 5 cycles after start edge, dot=10, max_val=10, max_idx=0, new_max=1.
REQ-035 Then inputs 15x4, weights 15x4, start -> dot=900, max_val=900, max_idx=1; repeat same start -> dot=900, new_max=0, max_idx=1.
REQ-036 All-zero banks, start immediately after reset -> dot=0, max_val=0, new_max=1 (have_max rule), max_idx=0.
REQ-037 start and in_valid pulsed while busy -> ignored, banks unchanged, in_ready=0; start+in_valid together in IDLE -> load only, busy stays 0.
REQ-038 clr asserted on DONE-entry edge -> done=1, dot updated, max_val=0, sample_cnt=0, new_max=0.
REQ-039 rst_n low at second MAC cycle -> busy=0 immediately, no done, all outputs 0; 256 evaluations after clr -> sample_cnt wraps to 0.
